mult_ctrl: RTL and testbench
============================

# mult_ctrl

Sequencer for the iterative Booth multiplier: accepts a multiply request, latches both operands, and steps the 5-bit shift count through 0..31 on the `shiftadder` datapath. It owns the datapath clear, so the accumulator always starts from zero. It collects the datapath's per-cycle overflow and captures the final product into its own result register. It sits between the multdiv top level (request side) and `shiftadder` (datapath side).

## Interface
Parameters:
- `NCYC`, 32, number of accumulate cycles; equals the operand width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `opA`  in  32  multiplicand; captured when `start` is accepted.
- `opB`  in  32  multiplier; captured when `start` is accepted.
- `dp_A`  out  32  latched multiplicand driven to the datapath.
- `dp_B`  out  32  latched multiplier driven to the datapath.
- `dp_ct`  out  5  shift count driven to the datapath.
- `dp_clr`  out  1  datapath accumulator clear (datapath reset input).
- `dp_result`  in  32  datapath accumulator value.
- `dp_ovf`  in  1  datapath add-overflow for the add committed at the current edge.
- `busy`  out  1  high in RUN and DONE.
- `rdy`  out  1  one-cycle pulse; `result`/`exc` are valid and held.
- `result`  out  32  captured product.
- `exc`  out  1  product-overflow exception for `result`.

## Operation
- States: IDLE, RUN, DONE. All outputs are registered or decoded from registered state.
- **IDLE**
  - `dp_clr=1`, `dp_ct=0`.
  - `start=1` at an edge: capture `opA`/`opB` into `dp_A`/`dp_B`, clear the sticky overflow, clear the MIN flag, go to RUN with counter 0.
  - `start=0`: stay in IDLE.
- **RUN**
  - `dp_clr=0`, `dp_ct`=counter.
  - At each edge: sticky |= `dp_ovf`, then counter += 1.
  - When the counter is NCYC-1 at an edge, go to DONE. The counter wraps to 0 and is not used further.
  - `start` is ignored; there is no abort and no queue.
- **DONE** (one cycle)
  - `dp_clr=0`, `dp_ct` held at 31.
  - At the edge: `result` <= `dp_result`, `exc` <= sticky | MIN flag, `rdy` <= 1, go to IDLE.
  - The extra datapath add in this cycle is discarded; the datapath is cleared again in IDLE.
- **MIN flag:** set at capture when `opA==32'h80000000` and `opB` is neither 0 nor 1. Negating INT_MIN wraps in the datapath, so that case is flagged here.
- `result`/`exc` hold their value until the next DONE. `rdy` is high only in the first IDLE cycle after DONE.
- **Reset:** state IDLE, counter 0, `dp_A=dp_B=0`, sticky 0, MIN flag 0, `result=0`, `exc=0`, `rdy=0`, `busy=0`, `dp_clr=1`.
  - Reset mid-RUN or mid-DONE abandons the operation: no `rdy`, and `result` is cleared to 0.

## Timing
- Let `start` be accepted at edge E0.
- Cycles C1..C32 are RUN with `dp_ct`=0..31; the add for count k commits at edge E(k+1).
- C33 is DONE; capture happens at E33.
- C34: `rdy=1` and state is IDLE. A `start` sampled at E34 is accepted, giving back-to-back throughput of 1 op per 34 cycles.
- Latency from E0 to `rdy` visible: 34 cycles.
- `dp_ovf` is sampled only at E1..E32; its value in IDLE or DONE is ignored.
- `start` held high continuously: accepted at each IDLE edge, i.e. every 34 cycles.

## Structure
- Shared package holds:
  - state encodings `S_IDLE=2'd0`, `S_RUN=2'd1`, `S_DONE=2'd2`;
  - `NCYC_DEF=32`;
  - `INT_MIN=32'h80000000`.
- Natural sub-module: `ct_counter`, a 5-bit synchronous counter with clear and enable, plus a terminal-count output (count==NCYC-1).
- The FSM, operand/result registers, sticky flag and MIN check stay in `mult_ctrl`.

## Test plan
The bench models the datapath: `dp_result`=A*B[k:0]-partial, plus injected `dp_ovf`.
- Reset, then `start` with opA=7, opB=6; model gives 42 -> `dp_ct` steps 0..31 over C1..C32, `rdy` pulses at C34, `result=42`, `exc=0`, `busy` high C1..C33.
- Same operation with `dp_ovf` forced high only while `dp_ct==5` -> `exc=1`. A second op with no injection -> `exc=0` (sticky cleared at capture).
- opA=32'h80000000, opB=32'hFFFFFFFF -> `exc=1`. opA=32'h80000000, opB=1 -> `exc=0`.
- `start` pulsed at C10 during RUN -> ignored; exactly one `rdy`, at C34.
- `start` held high for 100 cycles -> `rdy` at C34 and C68, each op captures the operands present at its accept edge.
- `rst` asserted at C20 -> next cycle IDLE, `dp_clr=1`, `result=0`, no `rdy`. A new op afterwards completes normally.

Source files
------------

// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the Booth multiplier sequencer and its shift counter.
package mult_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int          NCYC_DEF = 32;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;

  // Negating INT_MIN wraps in the datapath; only a multiplier of 0 or 1 keeps the product in range.
  function automatic logic is_min_case(input logic [31:0] a, input logic [31:0] b);
    return (a == INT_MIN) && (b != 32'd0) && (b != 32'd1);
  endfunction

endpackage

// File: rtl/mult_ctrl_ct_counter.sv
// Shift counter for the multiplier: synchronous clear/enable with a terminal-count flag.
module ct_counter
  import mult_ctrl_pkg::*;
#(
  parameter int NCYC = NCYC_DEF,
  localparam int CW  = $clog2(NCYC)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == CW'(NCYC - 1));

endmodule

// File: rtl/mult_ctrl.sv
// Sequencer for the iterative Booth multiplier: latches operands, steps the shift count,
// gathers per-cycle overflow and captures the final product.
module mult_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int NCYC = NCYC_DEF,
  localparam int CW  = $clog2(NCYC)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [31:0]   opA,
  input  logic [31:0]   opB,
  output logic [31:0]   dp_A,
  output logic [31:0]   dp_B,
  output logic [CW-1:0] dp_ct,
  output logic          dp_clr,
  input  logic [31:0]   dp_result,
  input  logic          dp_ovf,
  output logic          busy,
  output logic          rdy,
  output logic [31:0]   result,
  output logic          exc
);

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sticky_q, sticky_d;
  logic        min_q, min_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic        rdy_q, rdy_d;

  logic [CW-1:0] ct_count;
  logic          ct_tc;

  ct_counter #(.NCYC(NCYC)) u_ct (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_q == S_IDLE),
    .en    (state_q == S_RUN),
    .count (ct_count),
    .tc    (ct_tc)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sticky_d = sticky_q;
    min_d    = min_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = opA;
          b_d      = opB;
          sticky_d = 1'b0;
          min_d    = is_min_case(opA, opB);
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        sticky_d = sticky_q | dp_ovf;
        if (ct_tc) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // The datapath's extra add this cycle is irrelevant; its value from the last RUN edge is captured.
        result_d = dp_result;
        exc_d    = sticky_q | min_q;
        rdy_d    = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sticky_q <= 1'b0;
      min_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sticky_q <= sticky_d;
      min_q    <= min_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  // The counter has already wrapped by DONE, so the last shift count is held explicitly.
  always_comb begin
    dp_ct = '0;
    if (state_q == S_RUN) begin
      dp_ct = ct_count;
    end else if (state_q == S_DONE) begin
      dp_ct = CW'(NCYC - 1);
    end
  end

  assign dp_clr = (state_q == S_IDLE);
  assign busy   = (state_q != S_IDLE);
  assign dp_A   = a_q;
  assign dp_B   = b_q;
  assign rdy    = rdy_q;
  assign result = result_q;
  assign exc    = exc_q;

endmodule

// File: tb/tb_mult_ctrl.sv
// Self-checking bench for mult_ctrl: a behavioural shift-add datapath plus a product/exception
// reference computed directly from the operands and the injected overflow pattern.
module tb_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] opA, opB;
  logic [31:0] dp_A, dp_B;
  logic [4:0]  dp_ct;
  logic        dp_clr;
  logic [31:0] dp_result;
  logic        dp_ovf;
  logic        busy, rdy, exc;
  logic [31:0] result;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] held_a [0:101];
  logic [31:0] held_b [0:101];

  mult_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .opA       (opA),
    .opB       (opB),
    .dp_A      (dp_A),
    .dp_B      (dp_B),
    .dp_ct     (dp_ct),
    .dp_clr    (dp_clr),
    .dp_result (dp_result),
    .dp_ovf    (dp_ovf),
    .busy      (busy),
    .rdy       (rdy),
    .result    (result),
    .exc       (exc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] partial(input logic [31:0] a, input logic [31:0] b, input logic [4:0] ct);
    logic [32:0] msk;
    msk = (33'd1 << ({28'd0, ct} + 33'd1)) - 33'd1;
    return a * (b & msk[31:0]);
  endfunction

  // Datapath stand-in: accumulator holds A times the multiplier bits seen so far.
  logic [31:0] acc;
  always @(posedge clk) begin
    acc <= dp_clr ? 32'd0 : partial(dp_A, dp_B, dp_ct);
  end
  assign dp_result = acc;

  function automatic logic model_exc(input logic [31:0] a, input logic [31:0] b, input logic [31:0] mask);
    return (mask != 32'd0) || (a == 32'h8000_0000 && b != 32'd0 && b != 32'd1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation from IDLE; mask bit k drives dp_ovf during shift count k.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [31:0] mask,
                               input int pulse_at);
    logic [31:0] exp_r;
    logic        exp_e;
    exp_r  = a * b;
    exp_e  = model_exc(a, b, mask);
    start  = 1'b1;
    opA    = a;
    opB    = b;
    dp_ovf = 1'($urandom);
    tick();
    for (int k = 1; k <= 32; k++) begin
      dp_ovf = mask[k-1];
      start  = (k == pulse_at);
      opA    = $urandom;
      opB    = $urandom;
      @(negedge clk);
      checkOutput("dp_ct_run", 32'(dp_ct), 32'(k - 1));
      checkOutput("busy_run", 32'(busy), 32'd1);
      checkOutput("rdy_run", 32'(rdy), 32'd0);
      checkOutput("clr_run", 32'(dp_clr), 32'd0);
      if (k == 1) begin
        checkOutput("dp_A", dp_A, a);
        checkOutput("dp_B", dp_B, b);
      end
      tick();
    end
    start  = 1'b0;
    dp_ovf = 1'($urandom);
    @(negedge clk);
    checkOutput("busy_done", 32'(busy), 32'd1);
    checkOutput("dp_ct_done", 32'(dp_ct), 32'd31);
    checkOutput("rdy_done", 32'(rdy), 32'd0);
    tick();
    dp_ovf = 1'($urandom);
    @(negedge clk);
    checkOutput("rdy_pulse", 32'(rdy), 32'd1);
    checkOutput("busy_idle", 32'(busy), 32'd0);
    checkOutput("clr_idle", 32'(dp_clr), 32'd1);
    checkOutput("result", result, exp_r);
    checkOutput("exc", 32'(exc), 32'(exp_e));
    tick();
    @(negedge clk);
    checkOutput("rdy_drop", 32'(rdy), 32'd0);
    checkOutput("result_hold", result, exp_r);
    checkOutput("exc_hold", 32'(exc), 32'(exp_e));
  endtask

  initial begin
    logic [31:0] a, b, m;
    rst    = 1'b1;
    start  = 1'b0;
    opA    = '0;
    opB    = '0;
    dp_ovf = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rdy", 32'(rdy), 32'd0);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_exc", 32'(exc), 32'd0);
    checkOutput("rst_clr", 32'(dp_clr), 32'd1);
    checkOutput("rst_ct", 32'(dp_ct), 32'd0);
    checkOutput("rst_dpA", dp_A, 32'd0);
    checkOutput("rst_dpB", dp_B, 32'd0);

    applyStimulus(32'd7, 32'd6, 32'd0, 0);
    applyStimulus(32'd7, 32'd6, 32'h0000_0020, 0);
    applyStimulus(32'd7, 32'd6, 32'd0, 0);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
    applyStimulus(32'h8000_0000, 32'd1, 32'd0, 0);
    applyStimulus(32'hFFFF_FFFD, 32'd9, 32'h8000_0000, 0);

    for (int i = 0; i < 6; i++) begin
      a = ($urandom % 5 == 0) ? 32'h8000_0000 : $urandom;
      b = ($urandom % 4 == 0) ? ($urandom % 3) : $urandom;
      m = ($urandom % 2 == 0) ? 32'd0 : (32'd1 << ($urandom % 32));
      applyStimulus(a, b, m, 0);
    end

    // A start mid-RUN must be neither accepted nor queued.
    applyStimulus(32'd1234, 32'd5678, 32'd0, 10);
    for (int i = 0; i < 40; i++) begin
      tick();
      @(negedge clk);
      checkOutput("no_queue_rdy", 32'(rdy), 32'd0);
      checkOutput("no_queue_busy", 32'(busy), 32'd0);
    end

    // Continuous start: accepts at edges 0, 34 and 68.
    dp_ovf = 1'b0;
    for (int i = 0; i <= 101; i++) begin
      held_a[i] = $urandom;
      held_b[i] = $urandom;
      opA   = held_a[i];
      opB   = held_b[i];
      start = (i < 100);
      @(posedge clk);
      @(negedge clk);
      checkOutput("held_rdy", 32'(rdy), 32'((i % 34) == 33));
      if ((i % 34) == 33) begin
        checkOutput("held_result", result, held_a[i-33] * held_b[i-33]);
        checkOutput("held_exc", 32'(exc), 32'(model_exc(held_a[i-33], held_b[i-33], 32'd0)));
      end
    end
    start = 1'b0;
    tick();

    // Reset in the middle of an operation abandons it.
    applyStimulus(32'd1234, 32'd5678, 32'd0, 0);
    start = 1'b1;
    opA   = 32'd99;
    opB   = 32'd77;
    tick();
    start = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_clr", 32'(dp_clr), 32'd1);
    checkOutput("midrst_result", result, 32'd0);
    checkOutput("midrst_rdy", 32'(rdy), 32'd0);
    checkOutput("midrst_ct", 32'(dp_ct), 32'd0);
    for (int i = 0; i < 40; i++) begin
      tick();
      @(negedge clk);
      checkOutput("midrst_no_rdy", 32'(rdy), 32'd0);
    end
    applyStimulus(32'd12345, 32'd678, 32'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
